updown_seq_monitor: RTL
=======================

Name: updown_seq_monitor

Overview:
- Receive-side checker for the 3-bit bouncing up/down synchronous counter (0..7..0, reversing at the endpoints).
- Samples the count bus, acquires the count direction and tracks it.
- Flags any illegal step and counts direction turnarounds and errors.
- Sits on the consumer side of a counter bus; used for self-check in lab benches and for sequence supervision in the design.

Parameters:
- WIDTH, 3, width of the observed count bus; MAX = 2^WIDTH-1.
- TURN_W, 8, width of the turnaround counter.
- ERR_W, 8, width of the error counter.

Ports:
- clock  input  1  single system clock, rising edge.
- clear  input  1  synchronous, active-high reset.
- sample_valid  input  1  count_in is meaningful this cycle.
- count_in  input  WIDTH  observed counter value.
- locked  output  1  direction acquired; tracking the sequence.
- dir_up  output  1  current direction; 1 = counting up.
- turn_pulse  output  1  one-cycle pulse on a legal endpoint reversal.
- seq_error  output  1  illegal step detected (pulse, or sticky; see Optional Feature).
- turn_count  output  TURN_W  number of legal reversals; saturates at all-ones.
- err_count  output  ERR_W  number of illegal steps; saturates at all-ones.

Behaviour:
- All outputs are registered; a response appears the cycle after the sampling edge.
- clear is sampled on the rising edge of clock and has priority over everything.
- Reset values: locked=0, dir_up=1, turn_pulse=0, seq_error=0, turn_count=0, err_count=0, prev=0, state=IDLE.
- When sample_valid=0, no state changes; pulse outputs drop to 0.
- States: IDLE, ACQ, TRACK.
- IDLE, on sample_valid: prev<=count_in; go to ACQ. No error is possible in IDLE.
- ACQ, on sample_valid:
  - count_in==prev: stall; no change.
  - count_in==prev+1 (prev<MAX): dir_up<=1, locked<=1, go to TRACK.
  - count_in==prev-1 (prev>0): dir_up<=0, locked<=1, go to TRACK.
  - Otherwise: seq_error, err_count+1, stay in ACQ.
  - prev<=count_in in every case.
- TRACK: expected next value:
  - dir_up=1 and prev<MAX: prev+1.
  - dir_up=1 and prev==MAX: MAX-1, with reversal.
  - dir_up=0 and prev>0: prev-1.
  - dir_up=0 and prev==0: 1, with reversal.
- TRACK, on sample_valid:
  - count_in==prev: stall (enable low upstream); no error, no change.
  - count_in==expected: prev<=count_in. On reversal: dir_up toggles, turn_pulse=1, turn_count+1.
  - Otherwise: seq_error, err_count+1, locked<=0, prev<=count_in, go to ACQ.
- There is no modulo wrap: MAX->0 and 0->MAX are errors in both ACQ and TRACK.
- A step away from an endpoint in the wrong direction is an error (e.g. up at 4 -> 3).
- Counters saturate; they never wrap.
- clear mid-operation: all state returns to reset values on that edge, regardless of sample_valid.

Optional Feature:
- Macro: UDMON_STICKY_ERR_EN.
- Defined: seq_error latches at 1 on the first illegal step and holds until clear. err_count and relock behaviour are unchanged.
- Undefined: seq_error is a one-cycle pulse per illegal step.

Test Plan:
- clear=1 for 2 cycles, then feed samples 0,1,...,7,6,...,0,1 -> locked=1 after the 2nd sample; dir_up falls after 7->6 and rises after 0->1; turn_count=2; err_count=0.
- Samples 3,3,3,4 with valid held high -> no seq_error; locked=1, dir_up=1 after the 4.
- Locked up at 5, then sample 7 -> seq_error, err_count=1, locked=0; next sample 6 -> locked=1, dir_up=0.
- Locked down at 0, then sample 7 -> error (no wrap); up at 7, then sample 0 -> error.
- Mid-sequence (turn_count=3, err_count=2), assert clear together with sample_valid=1 -> all outputs at reset values next cycle; state IDLE.
- With UDMON_STICKY_ERR_EN defined, inject one error then a legal sequence -> seq_error stays 1 until clear. Without the macro -> seq_error is high exactly one cycle.

Source files
------------

// File: rtl/updown_seq_monitor_if.sv
// Count-bus interface between a bouncing up/down counter (master) and its
// sequence monitor (slave): sampled count plus the monitor's status outputs.
interface updown_seq_monitor_if #(
   parameter int WIDTH  = 3,
   parameter int TURN_W = 8,
   parameter int ERR_W  = 8
);
   logic              sample_valid;
   logic [WIDTH-1:0]  count_in;
   logic              locked;
   logic              dir_up;
   logic              turn_pulse;
   logic              seq_error;
   logic [TURN_W-1:0] turn_count;
   logic [ERR_W-1:0]  err_count;

   modport master (
      output sample_valid, count_in,
      input  locked, dir_up, turn_pulse, seq_error, turn_count, err_count
   );

   modport slave (
      input  sample_valid, count_in,
      output locked, dir_up, turn_pulse, seq_error, turn_count, err_count
   );
endinterface

// File: rtl/updown_seq_monitor.sv
// Receive-side checker for a bouncing 0..MAX..0 up/down counter bus.
// Optional macro UDMON_STICKY_ERR_EN: seq_error latches until clear instead of pulsing.
module updown_seq_monitor #(
   parameter int WIDTH  = 3,
   parameter int TURN_W = 8,
   parameter int ERR_W  = 8
) (
   input  logic                 clock,
   input  logic                 clear,
   updown_seq_monitor_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  prev, prev_n;
   logic              locked, locked_n;
   logic              dir_up, dir_n;
   logic              turn_pulse, turn_pulse_n;
   logic              seq_error, seq_error_n;
   logic [TURN_W-1:0] turn_count, turn_n;
   logic [ERR_W-1:0]  err_count, err_n;

   logic [WIDTH-1:0]  prev_inc, prev_dec, expect_val;
   logic              expect_rev;
   logic              step_err;

   function automatic logic [TURN_W-1:0] sat_turn(input logic [TURN_W-1:0] v);
      return (v == '1) ? v : v + TURN_W'(1);
   endfunction

   function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   assign prev_inc = prev + ONE;
   assign prev_dec = prev - ONE;

   // Next legal value while tracking; endpoints force a reversal, never a wrap.
   always_comb begin
      expect_val = prev_inc;
      expect_rev = 1'b0;
      if (dir_up) begin
         if (prev == MAX) begin
            expect_val = prev_dec;
            expect_rev = 1'b1;
         end
      end else if (prev == '0) begin
         expect_val = ONE;
         expect_rev = 1'b1;
      end else begin
         expect_val = prev_dec;
      end
   end

   always_comb begin
      state_n      = state;
      prev_n       = prev;
      locked_n     = locked;
      dir_n        = dir_up;
      turn_pulse_n = 1'b0;
      turn_n       = turn_count;
      err_n        = err_count;
      step_err     = 1'b0;
`ifdef UDMON_STICKY_ERR_EN
      seq_error_n  = seq_error;
`else
      seq_error_n  = 1'b0;
`endif
      if (bus.sample_valid) begin
         case (state)
            IDLE: begin
               prev_n  = bus.count_in;
               state_n = ACQ;
            end
            ACQ: begin
               prev_n = bus.count_in;
               if (bus.count_in != prev) begin
                  if (prev != MAX && bus.count_in == prev_inc) begin
                     dir_n    = 1'b1;
                     locked_n = 1'b1;
                     state_n  = TRACK;
                  end else if (prev != '0 && bus.count_in == prev_dec) begin
                     dir_n    = 1'b0;
                     locked_n = 1'b1;
                     state_n  = TRACK;
                  end else begin
                     step_err = 1'b1;
                  end
               end
            end
            TRACK: begin
               // Equal value means the upstream counter was stalled.
               if (bus.count_in != prev) begin
                  prev_n = bus.count_in;
                  if (bus.count_in == expect_val) begin
                     if (expect_rev) begin
                        dir_n        = ~dir_up;
                        turn_pulse_n = 1'b1;
                        turn_n       = sat_turn(turn_count);
                     end
                  end else begin
                     step_err = 1'b1;
                     locked_n = 1'b0;
                     state_n  = ACQ;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (step_err) begin
         seq_error_n = 1'b1;
         err_n       = sat_err(err_count);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= IDLE;
         prev       <= '0;
         locked     <= 1'b0;
         dir_up     <= 1'b1;
         turn_pulse <= 1'b0;
         seq_error  <= 1'b0;
         turn_count <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_n;
         prev       <= prev_n;
         locked     <= locked_n;
         dir_up     <= dir_n;
         turn_pulse <= turn_pulse_n;
         seq_error  <= seq_error_n;
         turn_count <= turn_n;
         err_count  <= err_n;
      end
   end

   assign bus.locked     = locked;
   assign bus.dir_up     = dir_up;
   assign bus.turn_pulse = turn_pulse;
   assign bus.seq_error  = seq_error;
   assign bus.turn_count = turn_count;
   assign bus.err_count  = err_count;
endmodule
